// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : 2-entry valid/ready skid buffer; in_ready is registered state only.
//            Optional stall counter enabled by `define PIPE_SKID_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
    parameter int            _W       = 32,
    parameter logic [_W-1:0] RST_VECT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [_W-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [_W-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    logic          r_main_v;
    logic          r_skid_v;
    logic [_W-1:0] r_main_d;
    logic [_W-1:0] r_skid_d;

    logic          w_in_fire;
    logic          w_out_fire;

    // Ready depends only on the skid flag, so a downstream stall never
    // propagates combinationally to the producer.
    assign in_ready   = ~r_skid_v & ~flush;
    assign out_valid  = r_main_v & ~flush;
    assign out_data   = flush ? '0 : r_main_d;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= RST_VECT;
            r_skid_d <= RST_VECT;
        end else begin
            case ({r_main_v, r_skid_v})
                2'b00: begin
                    if (w_in_fire) begin
                        r_main_v <= 1'b1;
                        r_main_d <= in_data;
                    end
                end
                2'b10: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_d <= in_data;
                    end else if (w_in_fire) begin
                        r_skid_v <= 1'b1;
                        r_skid_d <= in_data;
                    end else if (w_out_fire) begin
                        r_main_v <= 1'b0;
                    end
                end
                2'b11: begin
                    if (w_out_fire) begin
                        r_skid_v <= 1'b0;
                        r_main_d <= r_skid_d;
                    end
                end
                default: begin
                    // Skid valid without main valid is unreachable; recover to empty.
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating; flush deliberately leaves the count intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: directed scenarios plus randomized traffic
// checked against a queue-based model of a 2-deep FIFO.
`default_nettype none

module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    logic [31:0] m_stall = 32'd0;

    pipe_skid_stage #(
        ._W       (32),
        .RST_VECT (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the stage behaves as a 2-deep FIFO; flush/rst empty it.
    task automatic model_step();
        bit ir;
        bit ov;
        ir = (mq.size() < 2) && !flush;
        ov = (mq.size() > 0) && !flush;
        if (rst) begin
            mq.delete();
            m_stall = 32'd0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (ov && out_ready) void'(mq.pop_front());
            if (in_valid && ir) mq.push_back(in_data);
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        advance();
        advance();
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        advance();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            in_valid = (k < 8);
            in_data  = 32'(k + 1);
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
            total++; if (out_valid !== (k > 0)) begin bad++; $display("FAIL b2b_out_valid k=%0d got=%b exp=%b", k, out_valid, (k > 0)); end
            if (k > 0) begin
                total++; if (out_data !== 32'(k)) begin bad++; $display("FAIL b2b_out_data k=%0d got=%h exp=%h", k, out_data, 32'(k)); end
            end
            advance();
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
        advance();
    endtask

    task automatic test_stall_fill();
        logic [31:0] a, b, c;
        logic        t_iv[8]   = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic        t_or[8]   = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic        t_ir[8]   = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic        t_ov[8]   = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic [31:0] t_id[8];
        logic [31:0] t_od[8];
        a = 32'hAAAA_0001; b = 32'hBBBB_0002; c = 32'hCCCC_0003;
        t_id = '{a, b, c, c, c, c, 32'h0, 32'h0};
        t_od = '{32'h0, a, a, a, a, b, c, 32'h0};
        for (int k = 0; k < 8; k++) begin
            in_valid = t_iv[k]; in_data = t_id[k]; out_ready = t_or[k];
            @(negedge clk);
            total++; if (in_ready !== t_ir[k]) begin bad++; $display("FAIL fill_in_ready k=%0d got=%b exp=%b", k, in_ready, t_ir[k]); end
            total++; if (out_valid !== t_ov[k]) begin bad++; $display("FAIL fill_out_valid k=%0d got=%b exp=%b", k, out_valid, t_ov[k]); end
            if (t_ov[k]) begin
                total++; if (out_data !== t_od[k]) begin bad++; $display("FAIL fill_out_data k=%0d got=%h exp=%h", k, out_data, t_od[k]); end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1111_0001;
        advance();
        in_data = 32'h2222_0002;
        advance();
        flush = 1'b1; in_data = 32'h3333_0003; out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL flush_out_data got=%h exp=0", out_data); end
        advance();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_flush_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_flush_in_ready got=%b exp=1", in_ready); end
        advance();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5555_0005;
        advance();
        rst = 1'b1; in_valid = 1'b0;
        advance();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        advance();
    endtask

    task automatic test_random();
        bit          e_ir;
        bit          e_ov;
        int          nout = 0;
        for (int k = 0; k < 10000; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 97) == 0;
            in_data   = $urandom;
            @(negedge clk);
            e_ir = (mq.size() < 2) && !flush;
            e_ov = (mq.size() > 0) && !flush;
            total++; if (in_ready !== e_ir) begin bad++; $display("FAIL rnd_in_ready k=%0d got=%b exp=%b", k, in_ready, e_ir); end
            total++; if (out_valid !== e_ov) begin bad++; $display("FAIL rnd_out_valid k=%0d got=%b exp=%b", k, out_valid, e_ov); end
            if (e_ov) begin
                total++; if (out_data !== mq[0]) begin bad++; $display("FAIL rnd_out_data k=%0d got=%h exp=%h", k, out_data, mq[0]); end
                if (out_ready) nout++;
            end
            advance();
        end
        flush = 1'b0; in_valid = 1'b0;
        total++; if (nout < 1000) begin bad++; $display("FAIL rnd_activity got=%0d exp>=1000", nout); end
`ifdef PIPE_SKID_STALL_CNT_EN
        @(negedge clk);
        total++; if (stall_cnt !== m_stall) begin bad++; $display("FAIL rnd_stall_cnt got=%0d exp=%0d", stall_cnt, m_stall); end
        advance();
`endif
    endtask

`ifdef PIPE_SKID_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        advance();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'h7777_0007;
        advance();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) advance();
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_cnt_5 got=%0d exp=5", stall_cnt); end
        advance();
        out_ready = 1'b0; flush = 1'b1;
        advance();
        flush = 1'b0;
        @(negedge clk);
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_cnt_flush got=%0d exp=5", stall_cnt); end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        @(negedge clk);
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stall_cnt_rst got=%0d exp=0", stall_cnt); end
        advance();
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_stall_fill();
        test_flush();
        test_reset_mid();
`ifdef PIPE_SKID_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
